// File: rtl/dlsc_pcie_tlp_encoder_pkg.sv
// Shared TLP header encodings, FSM states and helpers for the TLP encoder.
package dlsc_pcie_tlp_encoder_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 11;  // up to 1024 data words + digest
  localparam int unsigned FMT_4DW_BIT  = 0;   // fmt[0]: 4DW header (64-bit address)
  localparam int unsigned FMT_DATA_BIT = 1;   // fmt[1]: TLP carries payload

  localparam logic [4:0] TYPE_CFG0 = 5'b00100;  // CfgRd0/CfgWr0 (CfgRd1 differs in bit 0)
  localparam logic [4:0] TYPE_CPL  = 5'b01010;  // Cpl/CplD
  localparam logic [4:0] TYPE_MSG  = 5'b10000;  // Msg, low 3 bits are routing

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DW0,
    ST_DW1,
    ST_DW2,
    ST_DW3,
    ST_PAYLOAD,
    ST_FLUSH
  } state_t;

  // One word headed for the output register.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } tx_word_t;

  function automatic logic is_cpl(input logic [4:0] t);
    return t == TYPE_CPL;
  endfunction

  function automatic logic is_msg(input logic [4:0] t);
    return t[4:3] == TYPE_MSG[4:3];
  endfunction

  function automatic logic is_cfg(input logic [4:0] t);
    return t[4:1] == TYPE_CFG0[4:1];
  endfunction

  // Payload words following the header, digest included; length 0 means 1024.
  function automatic logic [CNT_W-1:0] payload_words(input logic [1:0] fmt,
                                                     input logic [9:0] length,
                                                     input logic       digest);
    logic [CNT_W-1:0] n;
    n = '0;
    if (fmt[FMT_DATA_BIT]) begin
      n = (length == 10'd0) ? CNT_W'(1024) : CNT_W'(length);
    end
    return n + CNT_W'(digest);
  endfunction

endpackage

// File: rtl/dlsc_pcie_tlp_encoder.sv
// Serialises a TLP header plus payload into a 32-bit AXI-stream style transmit port.
module dlsc_pcie_tlp_encoder
  import dlsc_pcie_tlp_encoder_pkg::*;
#(
  parameter int unsigned USER_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,

  output logic                  tlp_ready,
  input  logic                  tlp_valid,
  input  logic [USER_WIDTH-1:0] tlp_user,
  input  logic [1:0]            tlp_fmt,
  input  logic [4:0]            tlp_type,
  input  logic [2:0]            traffic_class,
  input  logic                  digest_present,
  input  logic                  poisoned,
  input  logic [1:0]            attributes,
  input  logic [9:0]            length,
  input  logic [15:0]           src_id,
  input  logic [7:0]            src_tag,
  input  logic [3:0]            be_last,
  input  logic [3:0]            be_first,
  input  logic [63:2]           dest_addr,
  input  logic [15:0]           dest_id,
  input  logic [7:0]            msg_code,
  input  logic [9:0]            cfg_reg,
  input  logic [2:0]            cpl_status,
  input  logic                  cpl_bcm,
  input  logic [11:0]           cpl_bytes,
  input  logic [7:0]            cpl_tag,
  input  logic [6:0]            cpl_addr,

  output logic                  data_ready,
  input  logic                  data_valid,
  input  logic                  data_last,
  input  logic [DATA_W-1:0]     data,

  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic [DATA_W-1:0]     tx_data,
  output logic [USER_WIDTH-1:0] tx_user,

  output logic                  err_length
);

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [USER_WIDTH-1:0]   user_q, user_next;

  logic                    load_en;
  logic                    word_load_c;
  tx_word_t                word_c;
  logic [USER_WIDTH-1:0]   word_user_c;
  logic                    err_c;
  logic                    hdr_done_c;
  logic                    tlp_ready_c;
  logic                    data_ready_c;

  logic [DATA_W-1:0]       dw0, dw1, dw2, dw3;
  logic [CNT_W-1:0]        hdr_cnt;

  // Output register may take a new word when empty or being drained this cycle.
  assign load_en = !tx_valid || tx_ready;
  assign hdr_cnt = payload_words(tlp_fmt, length, digest_present);

  // Header words, built straight from the held header inputs.
  assign dw0 = {1'b0, tlp_fmt, tlp_type, 1'b0, traffic_class, 4'b0000,
                digest_present, poisoned, attributes, 2'b00, length};

  assign dw1 = is_cpl(tlp_type) ? {src_id, cpl_status, cpl_bcm, cpl_bytes} :
               is_msg(tlp_type) ? {src_id, src_tag, msg_code} :
                                  {src_id, src_tag, be_last, be_first};

  assign dw2 = is_cpl(tlp_type)         ? {dest_id, cpl_tag, 1'b0, cpl_addr} :
               is_cfg(tlp_type)         ? {dest_id, 4'b0000, cfg_reg, 2'b00} :
               tlp_fmt[FMT_4DW_BIT]     ? dest_addr[63:32] :
                                          {dest_addr[31:2], 2'b00};

  assign dw3 = {dest_addr[31:2], 2'b00};

  // State, payload counter and latched sideband user field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      user_q <= '0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      user_q <= user_next;
    end
  end

  // Next-state, word selection and handshake outputs.
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    user_next    = user_q;
    word_load_c  = 1'b0;
    word_c       = '0;
    word_user_c  = tlp_user;
    err_c        = 1'b0;
    hdr_done_c   = 1'b0;
    tlp_ready_c  = 1'b0;
    data_ready_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tlp_valid) next_state = ST_DW0;
      end
      ST_DW0: begin
        if (load_en) begin
          word_load_c = 1'b1;
          word_c.data = dw0;
          next_state  = ST_DW1;
        end
      end
      ST_DW1: begin
        if (load_en) begin
          word_load_c = 1'b1;
          word_c.data = dw1;
          next_state  = ST_DW2;
        end
      end
      ST_DW2: begin
        if (load_en) begin
          word_load_c = 1'b1;
          word_c.data = dw2;
          if (tlp_fmt[FMT_4DW_BIT]) next_state = ST_DW3;
          else                      hdr_done_c = 1'b1;
        end
      end
      ST_DW3: begin
        if (load_en) begin
          word_load_c = 1'b1;
          word_c.data = dw3;
          hdr_done_c  = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        data_ready_c = load_en;
        word_user_c  = user_q;
        if (data_valid && load_en) begin
          word_load_c = 1'b1;
          word_c.data = data;
          word_c.last = (cnt == CNT_W'(1)) || data_last;
          cnt_next    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1) && data_last) begin
            next_state = ST_IDLE;
          end else if (data_last) begin
            // Source ended early: close the TLP on this word.
            err_c      = 1'b1;
            cnt_next   = '0;
            next_state = ST_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            // Header length reached but source keeps going: drop the rest.
            err_c      = 1'b1;
            next_state = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        data_ready_c = 1'b1;
        if (data_valid && data_last) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    // Last header word: accept the header and decide whether payload follows.
    if (hdr_done_c) begin
      tlp_ready_c = 1'b1;
      user_next   = tlp_user;
      cnt_next    = hdr_cnt;
      if (hdr_cnt == '0) begin
        word_c.last = 1'b1;
        next_state  = ST_IDLE;
      end else begin
        next_state  = ST_PAYLOAD;
      end
    end

    if (rst) begin
      tlp_ready_c  = 1'b0;
      data_ready_c = 1'b0;
    end
  end

  assign tlp_ready  = tlp_ready_c;
  assign data_ready = data_ready_c;

  // Single output register; contents frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      tx_data    <= '0;
      tx_user    <= '0;
      err_length <= 1'b0;
    end else begin
      err_length <= err_c;
      if (load_en) begin
        tx_valid <= word_load_c;
        tx_last  <= word_load_c && word_c.last;
        if (word_load_c) begin
          tx_data <= word_c.data;
          tx_user <= word_user_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_dlsc_pcie_tlp_encoder.sv
// Directed bench for dlsc_pcie_tlp_encoder with hand-computed expected TLP words.
module tb_dlsc_pcie_tlp_encoder;

  logic        clk;
  logic        rst;
  logic        tlp_ready, tlp_valid;
  logic [6:0]  tlp_user;
  logic [1:0]  tlp_fmt;
  logic [4:0]  tlp_type;
  logic [2:0]  traffic_class;
  logic        digest_present, poisoned;
  logic [1:0]  attributes;
  logic [9:0]  length;
  logic [15:0] src_id;
  logic [7:0]  src_tag;
  logic [3:0]  be_last, be_first;
  logic [63:2] dest_addr;
  logic [15:0] dest_id;
  logic [7:0]  msg_code;
  logic [9:0]  cfg_reg;
  logic [2:0]  cpl_status;
  logic        cpl_bcm;
  logic [11:0] cpl_bytes;
  logic [7:0]  cpl_tag;
  logic [6:0]  cpl_addr;
  logic        data_ready, data_valid, data_last;
  logic [31:0] data;
  logic        tx_ready, tx_valid, tx_last;
  logic [31:0] tx_data;
  logic [6:0]  tx_user;
  logic        err_length;

  dlsc_pcie_tlp_encoder #(.USER_WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .tlp_ready(tlp_ready), .tlp_valid(tlp_valid), .tlp_user(tlp_user),
    .tlp_fmt(tlp_fmt), .tlp_type(tlp_type), .traffic_class(traffic_class),
    .digest_present(digest_present), .poisoned(poisoned), .attributes(attributes),
    .length(length), .src_id(src_id), .src_tag(src_tag), .be_last(be_last),
    .be_first(be_first), .dest_addr(dest_addr), .dest_id(dest_id),
    .msg_code(msg_code), .cfg_reg(cfg_reg), .cpl_status(cpl_status),
    .cpl_bcm(cpl_bcm), .cpl_bytes(cpl_bytes), .cpl_tag(cpl_tag), .cpl_addr(cpl_addr),
    .data_ready(data_ready), .data_valid(data_valid), .data_last(data_last), .data(data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data),
    .tx_user(tx_user), .err_length(err_length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tmo_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: records accepted tx words and watches stall stability.
  logic [31:0] mon_d[$];
  logic        mon_l[$];
  logic [6:0]  mon_u[$];
  int          err_cnt = 0, dr_cnt = 0, stall_viol = 0, stall_seen = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [6:0]  prev_user = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data ||
                         tx_last !== prev_last || tx_user !== prev_user))
        stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stall_seen++;
      prev_data = tx_data;
      prev_last = tx_last;
      prev_user = tx_user;
      if (tx_valid && tx_ready) begin
        mon_d.push_back(tx_data);
        mon_l.push_back(tx_last);
        mon_u.push_back(tx_user);
      end
      if (err_length) err_cnt++;
      if (data_ready) dr_cnt++;
    end
  end

  // tx_ready: constant 1, or random back-pressure when rdy_mode is set.
  logic rdy_mode = 1'b0;
  always begin
    @(posedge clk);
    #1;
    tx_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [6:0]  exp_u[$];

  task automatic expect_word(input logic [31:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
    exp_u.push_back(tlp_user);
  endtask

  task automatic clear_mon();
    mon_d.delete(); mon_l.delete(); mon_u.delete();
    err_cnt = 0;
    dr_cnt  = 0;
  endtask

  task automatic hdr_defaults(input logic [6:0] user);
    tlp_user = user; tlp_fmt = '0; tlp_type = '0; traffic_class = '0;
    digest_present = 1'b0; poisoned = 1'b0; attributes = '0; length = '0;
    src_id = 16'h0100; src_tag = '0; be_last = '0; be_first = '0; dest_addr = '0;
    dest_id = '0; msg_code = '0; cfg_reg = '0; cpl_status = '0; cpl_bcm = 1'b0;
    cpl_bytes = '0; cpl_tag = '0; cpl_addr = '0;
  endtask

  task automatic send_hdr(input string tag);
    logic got;
    got = 1'b0;
    tlp_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tlp_ready) begin got = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
    check({tag, "_hdr_accept"}, 64'(got), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    logic got;
    got = 1'b0;
    data_valid = 1'b1; data = d; data_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_ready) begin got = 1'b1; break; end
    end
    if (!got) tmo_cnt++;
    @(posedge clk);
    #1;
    data_valid = 1'b0; data_last = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 300 && mon_d.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    int lbad = 0, ubad = 0;
    check({tag, "_count"}, 64'(mon_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < mon_d.size()) begin
        check($sformatf("%s_w%0d", tag, i), 64'(mon_d[i]), 64'(exp_d[i]));
        if (mon_l[i] !== exp_l[i]) lbad++;
        if (mon_u[i] !== exp_u[i]) ubad++;
      end
    end
    check({tag, "_last"}, 64'(lbad), 64'd0);
    check({tag, "_user"}, 64'(ubad), 64'd0);
    exp_d.delete(); exp_l.delete(); exp_u.delete();
  endtask

  task automatic run_cfgrd(input string tag);
    clear_mon();
    hdr_defaults(7'h14);
    tlp_type = 5'b00100; length = 10'd1; src_tag = 8'h03; be_first = 4'hF;
    dest_id = 16'h0300; cfg_reg = 10'h010;
    expect_word(32'h04000001, 1'b0);
    expect_word(32'h0100030F, 1'b0);
    expect_word(32'h03000040, 1'b1);
    send_hdr(tag);
    wait_drain(3);
    verify(tag);
  endtask

  initial begin
    rst = 1'b1; tlp_valid = 1'b0; data_valid = 1'b0; data_last = 1'b0; data = '0;
    tx_ready = 1'b1;
    hdr_defaults(7'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid",   64'(tx_valid),   64'd0);
    check("rst_tx_last",    64'(tx_last),    64'd0);
    check("rst_tx_data",    64'(tx_data),    64'd0);
    check("rst_tx_user",    64'(tx_user),    64'd0);
    check("rst_tlp_ready",  64'(tlp_ready),  64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_err_length", 64'(err_length), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MWr32, 2 data words
    clear_mon();
    hdr_defaults(7'h11);
    tlp_fmt = 2'b10; length = 10'd2; src_tag = 8'h01; be_last = 4'hF; be_first = 4'hF;
    dest_addr = 62'h400;
    expect_word(32'h40000002, 1'b0);
    expect_word(32'h010001FF, 1'b0);
    expect_word(32'h00001000, 1'b0);
    expect_word(32'h0000000A, 1'b0);
    expect_word(32'h0000000B, 1'b1);
    send_hdr("mwr32");
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b1);
    wait_drain(5);
    verify("mwr32");
    check("mwr32_err", 64'(err_cnt), 64'd0);

    // MRd64, 4DW header, no payload
    clear_mon();
    hdr_defaults(7'h12);
    tlp_fmt = 2'b01; length = 10'd1; src_tag = 8'h02; be_first = 4'hF;
    dest_addr = 62'(64'h0000_0001_2345_6780 >> 2);
    expect_word(32'h20000001, 1'b0);
    expect_word(32'h0100020F, 1'b0);
    expect_word(32'h00000001, 1'b0);
    expect_word(32'h23456780, 1'b1);
    send_hdr("mrd64");
    wait_drain(4);
    verify("mrd64");
    check("mrd64_data_ready", 64'(dr_cnt), 64'd0);
    check("mrd64_err", 64'(err_cnt), 64'd0);

    // CplD, 1 data word
    clear_mon();
    hdr_defaults(7'h13);
    tlp_fmt = 2'b10; tlp_type = 5'b01010; length = 10'd1; src_id = 16'h0200;
    cpl_bytes = 12'd4; dest_id = 16'h0100; cpl_tag = 8'h5A; cpl_addr = 7'h04;
    expect_word(32'h4A000001, 1'b0);
    expect_word(32'h02000004, 1'b0);
    expect_word(32'h01005A04, 1'b0);
    expect_word(32'hDEADBEEF, 1'b1);
    send_hdr("cpld");
    send_word(32'hDEADBEEF, 1'b1);
    wait_drain(4);
    verify("cpld");

    // CfgRd0, 3DW, no payload
    run_cfgrd("cfgrd");

    // Message with digest only: payload count is the digest word
    clear_mon();
    hdr_defaults(7'h15);
    tlp_type = 5'b10100; digest_present = 1'b1; src_tag = 8'h04; msg_code = 8'h7F;
    expect_word(32'h14008000, 1'b0);
    expect_word(32'h0100047F, 1'b0);
    expect_word(32'h00000000, 1'b0);
    expect_word(32'hCAFEF00D, 1'b1);
    send_hdr("msg");
    send_word(32'hCAFEF00D, 1'b1);
    wait_drain(4);
    verify("msg");
    check("msg_err", 64'(err_cnt), 64'd0);

    // Early data_last: truncated TLP
    clear_mon();
    hdr_defaults(7'h16);
    tlp_fmt = 2'b10; length = 10'd4; src_tag = 8'h05; be_last = 4'hF; be_first = 4'hF;
    dest_addr = 62'h800;
    expect_word(32'h40000004, 1'b0);
    expect_word(32'h010005FF, 1'b0);
    expect_word(32'h00002000, 1'b0);
    expect_word(32'h00000011, 1'b0);
    expect_word(32'h00000022, 1'b1);
    send_hdr("trunc");
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b1);
    wait_drain(5);
    verify("trunc");
    check("trunc_err", 64'(err_cnt), 64'd1);

    // Too many data words: extras flushed
    clear_mon();
    hdr_defaults(7'h17);
    tlp_fmt = 2'b10; length = 10'd1; src_tag = 8'h06; be_last = 4'hF; be_first = 4'hF;
    dest_addr = 62'hC00;
    expect_word(32'h40000001, 1'b0);
    expect_word(32'h010006FF, 1'b0);
    expect_word(32'h00003000, 1'b0);
    expect_word(32'h00000033, 1'b1);
    send_hdr("over");
    send_word(32'h33, 1'b0);
    send_word(32'h44, 1'b0);
    send_word(32'h55, 1'b1);
    wait_drain(4);
    verify("over");
    check("over_err", 64'(err_cnt), 64'd1);

    // Back-to-back TLPs under random back-pressure
    clear_mon();
    rdy_mode = 1'b1;
    hdr_defaults(7'h21);
    tlp_fmt = 2'b10; length = 10'd3; traffic_class = 3'd5; poisoned = 1'b1;
    attributes = 2'd2; src_tag = 8'h07; be_last = 4'hF; be_first = 4'hF;
    dest_addr = 62'h1000;
    expect_word(32'h40506003, 1'b0);
    expect_word(32'h010007FF, 1'b0);
    expect_word(32'h00004000, 1'b0);
    expect_word(32'h00000001, 1'b0);
    expect_word(32'h00000002, 1'b0);
    expect_word(32'h00000003, 1'b1);
    send_hdr("b2b_a");
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h3, 1'b1);
    hdr_defaults(7'h42);
    tlp_fmt = 2'b10; length = 10'd2; src_tag = 8'h08; be_last = 4'hF; be_first = 4'hF;
    dest_addr = 62'h1400;
    expect_word(32'h40000002, 1'b0);
    expect_word(32'h010008FF, 1'b0);
    expect_word(32'h00005000, 1'b0);
    expect_word(32'h00000010, 1'b0);
    expect_word(32'h00000020, 1'b1);
    send_hdr("b2b_b");
    send_word(32'h10, 1'b0);
    send_word(32'h20, 1'b1);
    wait_drain(11);
    verify("b2b");
    check("b2b_err", 64'(err_cnt), 64'd0);
    rdy_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a payload
    clear_mon();
    hdr_defaults(7'h18);
    tlp_fmt = 2'b10; length = 10'd4; be_last = 4'hF; be_first = 4'hF;
    send_hdr("rstmid");
    send_word(32'h66, 1'b0);
    send_word(32'h77, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_tx_valid",   64'(tx_valid),   64'd0);
    check("rstmid_tx_last",    64'(tx_last),    64'd0);
    check("rstmid_data_ready", 64'(data_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_cfgrd("after_rst");

    check("no_timeouts",   64'(tmo_cnt),        64'd0);
    check("stall_stable",  64'(stall_viol),     64'd0);
    check("stalls_seen",   64'(stall_seen > 0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
